// File: rtl/seven_seg_capture_pkg.sv
// Shared definitions for 7-segment capture/decode: glyph table, digit count, FSM states.
package seven_seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    // Active-high segment patterns in {g,f,e,d,c,b,a} order, indexed by hex value
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } capture_state_e;

endpackage

// File: rtl/seven_seg_capture_seg_glyph_decode.sv
// Combinational 7-segment pattern (active-high, g..a) to hex nibble decoder.
module seg_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       ok,
    output logic [3:0] nibble
);

    always_comb begin
        ok     = 1'b0;
        nibble = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (pattern == GLYPH_TABLE[i]) begin
                ok     = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Reconstructs a multiplexed 7-segment scan into a decoded 8-digit frame.
// Optional SEVEN_SEG_CAPTURE_DP_EN adds the frame_dp output.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        clk100mhz,
    input  logic        rst,
    input  logic [7:0]  an_in,
    input  logic [6:0]  seg_in,
    input  logic        dp_in,
    output logic [31:0] frame_hex,
    output logic [7:0]  frame_ok,
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    output logic [7:0]  frame_dp,
`endif
    output logic        frame_valid,
    output logic        multi_err
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    capture_state_e state_q, state_d, cur_state;
    logic [15:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [15:0] cnt_q, cnt_d, eff_cnt;
    logic [7:0]  seen_q, seen_d;
    logic [31:0] slot_hex_q, slot_hex_d, frame_hex_q, frame_hex_d;
    logic [7:0]  slot_ok_q, slot_ok_d, frame_ok_q, frame_ok_d;
    logic        frame_valid_q, frame_valid_d, multi_err_q, multi_err_d;
    logic [7:0]  an_s;
    logic [6:0]  seg_s;
    logic        changed, capture, complete, dec_ok;
    logic [3:0]  low_count, dec_nibble;
    logic [2:0]  low_idx;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    logic [7:0]  slot_dp_q, slot_dp_d, frame_dp_q, frame_dp_d;
    logic        dp_s;
`endif

    seg_glyph_decode u_decode (
        .pattern (~seg_s),
        .ok      (dec_ok),
        .nibble  (dec_nibble)
    );

    always_comb begin
        sync1_d = {an_in, seg_in, dp_in};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        an_s    = sync2_q[15:8];
        seg_s   = sync2_q[7:1];
`ifdef SEVEN_SEG_CAPTURE_DP_EN
        dp_s    = sync2_q[0];
`endif

        low_count = '0;
        low_idx   = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s[i]) begin
                low_count = low_count + 4'd1;
                low_idx   = 3'(i);
            end
        end

        // A change restarts the stability count in the same cycle it is seen
        changed   = (sync2_q != prev_q);
        eff_cnt   = changed ? '0 : cnt_q;
        cnt_d     = (eff_cnt == '1) ? eff_cnt : eff_cnt + 16'd1;
        cur_state = changed ? ((low_count == 4'd1) ? SETTLE : IDLE) : state_q;

        state_d     = cur_state;
        capture     = 1'b0;
        multi_err_d = 1'b0;
        if (cur_state != HELD && eff_cnt == SETTLE_LAST) begin
            if (low_count == 4'd1) begin
                capture = 1'b1;
                state_d = HELD;
            end else if (low_count > 4'd1) begin
                multi_err_d = 1'b1;
                state_d     = HELD;
            end
        end

        complete      = (seen_q == '1);
        frame_valid_d = complete;
        frame_hex_d   = complete ? slot_hex_q : frame_hex_q;
        frame_ok_d    = complete ? slot_ok_q : frame_ok_q;
        seen_d        = complete ? '0 : seen_q;
        slot_hex_d    = slot_hex_q;
        slot_ok_d     = slot_ok_q;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
        frame_dp_d    = complete ? slot_dp_q : frame_dp_q;
        slot_dp_d     = slot_dp_q;
`endif
        if (capture) begin
            seen_d[low_idx]                   = 1'b1;
            slot_hex_d[{low_idx, 2'b00} +: 4] = dec_nibble;
            slot_ok_d[low_idx]                = dec_ok;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
            slot_dp_d[low_idx]                = ~dp_s;
`endif
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            state_q       <= IDLE;
            sync1_q       <= '1;
            sync2_q       <= '1;
            prev_q        <= '1;
            cnt_q         <= '0;
            seen_q        <= '0;
            slot_hex_q    <= '0;
            slot_ok_q     <= '0;
            frame_hex_q   <= '0;
            frame_ok_q    <= '0;
            frame_valid_q <= 1'b0;
            multi_err_q   <= 1'b0;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
            slot_dp_q     <= '0;
            frame_dp_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            slot_hex_q    <= slot_hex_d;
            slot_ok_q     <= slot_ok_d;
            frame_hex_q   <= frame_hex_d;
            frame_ok_q    <= frame_ok_d;
            frame_valid_q <= frame_valid_d;
            multi_err_q   <= multi_err_d;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
            slot_dp_q     <= slot_dp_d;
            frame_dp_q    <= frame_dp_d;
`endif
        end
    end

    assign frame_hex   = frame_hex_q;
    assign frame_ok    = frame_ok_q;
    assign frame_valid = frame_valid_q;
    assign multi_err   = multi_err_q;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    assign frame_dp    = frame_dp_q;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: run-length reference model plus directed and random scans.
module tb_seven_seg_capture;

    localparam int unsigned S = 16;

    logic        clk100mhz = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  an_in = 8'hFF;
    logic [6:0]  seg_in = 7'h7F;
    logic        dp_in = 1'b1;
    logic [31:0] frame_hex;
    logic [7:0]  frame_ok;
    logic        frame_valid, multi_err;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    logic [7:0]  frame_dp;
`endif

    always #5 clk100mhz = ~clk100mhz;

    seven_seg_capture #(.SETTLE_CYCLES(S)) dut (
        .clk100mhz   (clk100mhz),
        .rst         (rst),
        .an_in       (an_in),
        .seg_in      (seg_in),
        .dp_in       (dp_in),
        .frame_hex   (frame_hex),
        .frame_ok    (frame_ok),
`ifdef SEVEN_SEG_CAPTURE_DP_EN
        .frame_dp    (frame_dp),
`endif
        .frame_valid (frame_valid),
        .multi_err   (multi_err)
    );

    logic [6:0] glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int unsigned n_tests = 0, n_fail = 0;
    int unsigned valid_seen = 0, multi_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: inputs reach the decision logic two edges late; a run of
    // identical {an,seg,dp} values acts once, when it reaches S cycles long.
    logic [15:0] st1, st2, run_val;
    int          run_len;
    logic        ev_cap, ev_multi, ev_ok, ev_dp;
    int          ev_digit;
    logic [3:0]  ev_nib;
    logic [3:0]  m_nib [8];
    logic        m_ok [8], m_dp [8], m_seen [8];
    logic [31:0] exp_hex;
    logic [7:0]  exp_ok, exp_dp;
    logic        exp_valid, exp_multi;

    task automatic model_step(input logic r, input logic [15:0] v);
        int   zeros, idx;
        logic all_seen;
        if (r) begin
            st1 = '1; st2 = '1; run_val = '1; run_len = 1;
            ev_cap = 0; ev_multi = 0;
            for (int d = 0; d < 8; d++) begin
                m_nib[d] = 0; m_ok[d] = 0; m_dp[d] = 0; m_seen[d] = 0;
            end
            exp_hex = 0; exp_ok = 0; exp_dp = 0; exp_valid = 0; exp_multi = 0;
            return;
        end
        all_seen = 1;
        for (int d = 0; d < 8; d++) all_seen &= m_seen[d];
        exp_valid = all_seen;
        exp_multi = ev_multi;
        if (all_seen) begin
            for (int d = 0; d < 8; d++) begin
                exp_hex[4*d +: 4] = m_nib[d];
                exp_ok[d] = m_ok[d];
                exp_dp[d] = m_dp[d];
                m_seen[d] = 0;
            end
        end
        if (ev_cap) begin
            m_nib[ev_digit] = ev_nib; m_ok[ev_digit] = ev_ok;
            m_dp[ev_digit] = ev_dp; m_seen[ev_digit] = 1;
        end
        ev_cap = 0; ev_multi = 0;
        st2 = st1; st1 = v;
        if (st2 == run_val) run_len++;
        else begin
            run_val = st2; run_len = 1;
        end
        if (run_len == S) begin
            zeros = 0; idx = 0;
            for (int d = 0; d < 8; d++) if (!run_val[8+d]) begin zeros++; idx = d; end
            if (zeros == 1) begin
                ev_cap = 1; ev_digit = idx; ev_ok = 0; ev_nib = 0;
                ev_dp = ~run_val[0];
                for (int g = 0; g < 16; g++)
                    if (~run_val[7:1] == glyph[g]) begin ev_ok = 1; ev_nib = 4'(g); end
            end else if (zeros > 1) begin
                ev_multi = 1;
            end
        end
    endtask

    always @(posedge clk100mhz) begin
        model_step(rst, {an_in, seg_in, dp_in});
        #1;
        check("frame_hex", frame_hex, exp_hex);
        check("frame_ok", {24'd0, frame_ok}, {24'd0, exp_ok});
        check("frame_valid", {31'd0, frame_valid}, {31'd0, exp_valid});
        check("multi_err", {31'd0, multi_err}, {31'd0, exp_multi});
`ifdef SEVEN_SEG_CAPTURE_DP_EN
        check("frame_dp", {24'd0, frame_dp}, {24'd0, exp_dp});
`endif
        if (frame_valid) valid_seen++;
        if (multi_err) multi_seen++;
    end

    task automatic hold(input logic [7:0] a, input logic [6:0] s, input logic d, input int n);
        an_in = a; seg_in = s; dp_in = d;
        repeat (n) @(negedge clk100mhz);
    endtask

    task automatic blank(input int n);
        hold(8'hFF, 7'h7F, 1'b1, n);
    endtask

    task automatic scan(input logic [31:0] hexv, input logic [7:0] bad, input logic [7:0] dpm,
                        input int n, input int ndig);
        logic [7:0] a;
        logic [6:0] s;
        for (int i = 0; i < ndig; i++) begin
            a = 8'd1 << i;
            s = bad[i] ? ~7'h49 : ~glyph[hexv[4*i +: 4]];
            hold(~a, s, ~dpm[i], n);
        end
    endtask

    initial begin
        int unsigned v0, m0, r, x, y;
        logic [7:0] a;
        logic [6:0] s;
        repeat (3) @(negedge clk100mhz);
        check("reset_hex", frame_hex, 32'h0);
        check("reset_ok", {24'd0, frame_ok}, 32'h0);
        rst = 1'b0;
        blank(5);

        v0 = valid_seen;
        scan(32'h76543210, 8'h00, 8'h00, 100, 8);
        blank(30);
        check("scan_valid_count", valid_seen - v0, 1);
        check("scan_hex", frame_hex, 32'h76543210);
        check("scan_ok", {24'd0, frame_ok}, 32'hFF);

        v0 = valid_seen;
        scan(32'hFEDCBA98, 8'h00, 8'h00, 10, 8);
        blank(30);
        check("short_hold_no_valid", valid_seen - v0, 0);
        check("short_hold_hex_kept", frame_hex, 32'h76543210);

        v0 = valid_seen;
        scan(32'hFEDCBA98, 8'h00, 8'h00, 16, 8);
        blank(30);
        check("exact_hold_valid", valid_seen - v0, 1);
        check("exact_hold_hex", frame_hex, 32'hFEDCBA98);

        v0 = valid_seen; m0 = multi_seen;
        hold(8'hFC, ~glyph[1], 1'b1, 50);
        blank(10);
        check("multi_once", multi_seen - m0, 1);
        check("multi_no_valid", valid_seen - v0, 0);

        scan(32'h76543210, 8'h08, 8'h00, 20, 8);
        blank(30);
        check("illegal_ok", {24'd0, frame_ok}, 32'hF7);
        check("illegal_hex", frame_hex, 32'h76540210);

        scan(32'h11111111, 8'h00, 8'h00, 20, 5);
        hold(~8'h20, ~glyph[5], 1'b1, 8);
        rst = 1'b1;
        blank(2);
        check("midreset_hex", frame_hex, 32'h0);
        rst = 1'b0;
        v0 = valid_seen;
        scan(32'h89ABCDEF, 8'h00, 8'h00, 20, 7);
        check("midreset_7_digits", valid_seen - v0, 0);
        hold(~8'h80, ~glyph[8], 1'b1, 20);
        blank(30);
        check("midreset_valid", valid_seen - v0, 1);
        check("midreset_hex_after", frame_hex, 32'h89ABCDEF);

        scan(32'h01234567, 8'h00, 8'h81, 20, 8);
        blank(30);
        check("dp_scan_hex", frame_hex, 32'h01234567);
`ifdef SEVEN_SEG_CAPTURE_DP_EN
        check("dp_mask", {24'd0, frame_dp}, 32'h81);
`endif

        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            x = $urandom_range(0, 7);
            if (r < 7) a = ~(8'd1 << x);
            else if (r == 7) a = 8'hFF;
            else begin
                y = (x + $urandom_range(1, 7)) % 8;
                a = ~((8'd1 << x) | (8'd1 << y));
            end
            s = ($urandom_range(0, 3) != 0) ? ~glyph[$urandom_range(0, 15)] : 7'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                hold(a, s, 1'($urandom), $urandom_range(1, 2));
                rst = 1'b0;
            end
            hold(a, s, 1'($urandom), $urandom_range(1, 40));
        end
        blank(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Receive-side counterpart of the multiplexed 7-segment scan interface: samples the active-low anode and cathode lines, reconstructs which pattern is lit on each of the 8 digits, and decodes each pattern to a hex nibble.
- Used for board loopback and self-check of the display path: scan outputs are wired back into this block, and a host or LED compares the reconstructed frame.

Parameters:
- SETTLE_CYCLES, 16, cycles an anode/segment combination must be stable before capture (range 1..65535).
- NUM_DIGITS, 8, number of anodes; fixed at 8 in this revision.

Ports:
- clk100mhz  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- an_in  in  8  anode lines, active low, bit i = an i.
- seg_in  in  7  cathodes, active low, bit0=ca … bit6=cg.
- dp_in  in  1  decimal-point cathode, active low.
- frame_hex  out  32  decoded nibbles, [4i+3:4i] = digit i.
- frame_ok  out  8  bit i = digit i decoded to a legal hex glyph.
- frame_valid  out  1  one-cycle pulse when frame_hex/frame_ok update.
- multi_err  out  1  one-cycle pulse when >1 anode is low after settling.

Behaviour:
- Inputs pass through a 2-flop synchroniser; all timing below is counted from synchroniser output, so input-to-capture latency = 2 + SETTLE_CYCLES + 1 cycles.
- FSM states:
  - IDLE: entered when no anode or more than one anode is low.
  - SETTLE: a single anode is low; the settle counter runs.
  - HELD: the digit has been captured; wait for a change.
- Change detect: any difference in {an, seg, dp} from the previous cycle returns the FSM to SETTLE (or IDLE) and clears the counter.
- SETTLE: when the counter reaches SETTLE_CYCLES-1 with inputs unchanged:
  - if one anode is low: capture into slot i, set seen[i], go to HELD.
  - if more than one anode is low: pulse multi_err, no capture, go to HELD.
- All anodes high (blanking): IDLE, nothing captured.
- The settle counter saturates and never wraps.
- Decode: invert seg to active-high and look up {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - No match gives nibble 0 and ok=0.
- Re-capture of a slot already seen in the current frame overwrites that slot.
- Frame completion: the cycle after seen == 8'hFF:
  - frame_hex and frame_ok load from the slots;
  - frame_valid pulses for 1 cycle;
  - seen clears.
- A capture arriving in the same cycle as completion goes into the next frame.
- Reset (at any time, including mid-settle): FSM=IDLE, counter=0, seen=0, slots=0, frame_hex=0, frame_ok=0, frame_valid=0, multi_err=0, synchronisers = all ones (inactive).

Optional Feature:
- Macro: SEVEN_SEG_CAPTURE_DP_EN.
- Defined:
  - adds output port frame_dp [7:0], bit i = dp of digit i (active high);
  - frame_dp updates with frame_valid and resets to 0.
- Undefined:
  - no frame_dp port;
  - dp_in is still synchronised and still participates in change detection.

Decomposition:
- Shared package seven_seg_pkg holds:
  - the 16-entry glyph constant table (active-high, g..a order);
  - NUM_DIGITS;
  - the FSM state typedef {IDLE, SETTLE, HELD}.
- One sub-module is natural: seg_glyph_decode, a combinational 7-bit pattern to {ok, nibble}, shared with future display blocks.

Test Plan:
- Reset, then scan 8 digits with an=FE,FD,…,7F and pins seg=~{3F,06,5B,4F,66,6D,7D,07}, each held 100 cycles -> one frame_valid pulse, frame_hex=32'h76543210, frame_ok=8'hFF.
- Hold each digit 10 cycles with SETTLE_CYCLES=16 -> no capture and no frame_valid; 16 cycles -> capture.
- an=8'hFC held 50 cycles -> multi_err pulses exactly once, seen unchanged.
- Digit 3 pattern seg=~7'h49 (illegal) within a full scan -> frame_ok=8'hF7, nibble 3 = 0.
- Assert rst mid-SETTLE after 5 digits captured, then release and perform a full scan -> frame_valid only after all 8 new digits; frame_hex starts at 0 after reset.
- With SEVEN_SEG_CAPTURE_DP_EN, dp low on digits 0 and 7 -> frame_dp=8'h81.
